// File: rtl/vga_sync_gen.sv
// Raster timing generator: h/v counters on a pixel enable, registered sync,
// video-on and active-area coordinates, all decoded from the same (h, v).
module vga_sync_gen #(
    parameter int hres = 1024,
    parameter int hfp  = 24,
    parameter int hsw  = 136,
    parameter int hbp  = 160,
    parameter int vres = 768,
    parameter int vfp  = 3,
    parameter int vsw  = 6,
    parameter int vbp  = 29,
    parameter bit hpol = 1'b0,
    parameter bit vpol = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       von,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam logic [10:0] HRES  = 11'(hres);
    localparam logic [10:0] HS0   = 11'(hres + hfp);
    localparam logic [10:0] HS1   = 11'(hres + hfp + hsw);
    localparam logic [10:0] HLAST = 11'(hres + hfp + hsw + hbp - 1);
    localparam logic [10:0] VRES  = 11'(vres);
    localparam logic [10:0] VS0   = 11'(vres + vfp);
    localparam logic [10:0] VS1   = 11'(vres + vfp + vsw);
    localparam logic [10:0] VLAST = 11'(vres + vfp + vsw + vbp - 1);

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        von_q, von_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        fs_q, fs_d;
    logic        hact, vact;

    always_comb begin
        h_d  = h_q + 11'd1;
        v_d  = v_q;
        if (h_q == HLAST) begin
            h_d = '0;
            v_d = (v_q == VLAST) ? '0 : v_q + 11'd1;
        end
        hact  = h_q < HRES;
        vact  = v_q < VRES;
        von_d = hact && vact;
        x_d   = hact ? h_q[9:0] : '0;
        y_d   = vact ? v_q[9:0] : '0;
        // vsync decodes v only, so it moves exactly at the line wrap
        hs_d  = (h_q >= HS0 && h_q < HS1) ? hpol : ~hpol;
        vs_d  = (v_q >= VS0 && v_q < VS1) ? vpol : ~vpol;
        fs_d  = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= ~hpol;
            vs_q  <= ~vpol;
            von_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
        end else if (pix_en) begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fs_q  <= fs_d;
        end else begin
            fs_q  <= 1'b0;
        end
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign von         = von_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;

endmodule
